// File: rtl/axi_regmap_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_regmap_responder
// Description : AXI4-Lite slave register map with RW, W1C, W1S and read-only bits.
//               Define AXI_REGMAP_WSTRB_EN to make writes honour s_axi_wstrb.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_regmap_responder #(
  parameter int                       ADDR_WIDTH  = 6,
  parameter int                       NUM_REGS    = 8,
  parameter logic [NUM_REGS*32-1:0]   RW_MASK     = '0,
  parameter logic [NUM_REGS*32-1:0]   W1C_MASK    = '0,
  parameter logic [NUM_REGS*32-1:0]   W1S_MASK    = '0,
  parameter logic [NUM_REGS*32-1:0]   RESET_VALUE = '0
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic [2:0]               s_axi_awprot,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  output logic [1:0]               s_axi_bresp,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [2:0]               s_axi_arprot,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  input  logic [NUM_REGS*32-1:0]   hw_status,
  input  logic [NUM_REGS*32-1:0]   hw_set,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS*32-1:0]   reg_pulse
);

  localparam int                  c_idx_w      = ADDR_WIDTH - 2;
  localparam int                  c_nbits      = NUM_REGS * 32;
  localparam logic [31:0]         c_nregs      = 32'(NUM_REGS);
  localparam logic [1:0]          c_resp_okay  = 2'b00;
  localparam logic [1:0]          c_resp_slverr = 2'b10;

  // Overlapping masks resolve as W1C > W1S > RW.
  localparam logic [c_nbits-1:0]  c_w1c_mask   = W1C_MASK;
  localparam logic [c_nbits-1:0]  c_w1s_mask   = W1S_MASK & ~W1C_MASK;
  localparam logic [c_nbits-1:0]  c_rw_mask    = RW_MASK & ~W1C_MASK & ~W1S_MASK;
  localparam logic [c_nbits-1:0]  c_ro_mask    = ~(RW_MASK | W1C_MASK | W1S_MASK);
  localparam logic [c_nbits-1:0]  c_store_rst  = RESET_VALUE & c_rw_mask;

  typedef enum logic [2:0] {
    W_IDLE    = 3'd0,
    W_WAIT_W  = 3'd1,
    W_WAIT_AW = 3'd2,
    W_COMMIT  = 3'd3,
    W_RESP    = 3'd4
  } wstate_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_RDATA = 1'b1
  } rstate_e;

  wstate_e               wstate_q, wstate_d;
  rstate_e               rstate_q, rstate_d;
  logic                  run_q;
  logic [c_idx_w-1:0]    awidx_q, awidx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [c_nbits-1:0]    store_q, store_d;
  logic [c_nbits-1:0]    pulse_q, pulse_d;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic                  wr_valid;
  logic                  rd_valid;
  logic [31:0]           wr_be;
  logic [c_idx_w-1:0]    ar_idx;
  logic [31:0]           rd_word;

  assign ar_idx   = s_axi_araddr[ADDR_WIDTH-1:2];
  assign wr_valid = (32'(awidx_q) < c_nregs);
  assign rd_valid = (32'(ar_idx) < c_nregs);

`ifdef AXI_REGMAP_WSTRB_EN
  assign wr_be = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
`else
  assign wr_be = 32'hFFFF_FFFF;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]
`ifndef AXI_REGMAP_WSTRB_EN
                           , wstrb_q
`endif
                          };

  // run_q keeps every ready low until the first edge after reset release.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      run_q    <= 1'b0;
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      awidx_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      store_q  <= c_store_rst;
      pulse_q  <= '0;
    end else begin
      run_q    <= 1'b1;
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      awidx_q  <= awidx_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      store_q  <= store_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    wstate_d      = wstate_q;
    awidx_d       = awidx_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    bresp_d       = bresp_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    commit        = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        s_axi_awready = run_q;
        s_axi_wready  = run_q;
        aw_hs         = s_axi_awvalid & run_q;
        w_hs          = s_axi_wvalid & run_q;
        if (aw_hs && w_hs) begin
          wstate_d = W_COMMIT;
        end else if (aw_hs) begin
          wstate_d = W_WAIT_W;
        end else if (w_hs) begin
          wstate_d = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        s_axi_wready = 1'b1;
        w_hs         = s_axi_wvalid;
        if (w_hs) wstate_d = W_COMMIT;
      end
      W_WAIT_AW: begin
        s_axi_awready = 1'b1;
        aw_hs         = s_axi_awvalid;
        if (aw_hs) wstate_d = W_COMMIT;
      end
      W_COMMIT: begin
        commit   = 1'b1;
        bresp_d  = wr_valid ? c_resp_okay : c_resp_slverr;
        wstate_d = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    if (aw_hs) awidx_d = s_axi_awaddr[ADDR_WIDTH-1:2];
    if (w_hs) begin
      wdata_d = s_axi_wdata;
      wstrb_d = s_axi_wstrb;
    end
  end

  // Per-register storage: hw_set is OR-ed in after the clear, so a same-cycle set wins.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    localparam logic [31:0] c_rw  = c_rw_mask[r*32 +: 32];
    localparam logic [31:0] c_w1c = c_w1c_mask[r*32 +: 32];
    localparam logic [31:0] c_w1s = c_w1s_mask[r*32 +: 32];
    logic        hit;
    logic [31:0] cur;
    logic [31:0] wmask;
    logic [31:0] wr_ones;

    assign hit     = commit && wr_valid && (awidx_q == c_idx_w'(r));
    assign cur     = store_q[r*32 +: 32];
    assign wmask   = hit ? wr_be : 32'h0;
    assign wr_ones = wmask & wdata_q;

    assign store_d[r*32 +: 32] = (c_rw  & ((cur & ~wmask) | wr_ones))
                               | (c_w1c & ((cur & ~wr_ones) | hw_set[r*32 +: 32]));
    assign pulse_d[r*32 +: 32] = c_w1s & wr_ones;
  end

  // store_q only ever holds RW/W1C bits, so W1S bits read back as zero.
  always_comb begin
    rd_word = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (ar_idx == c_idx_w'(r)) begin
        rd_word = store_q[r*32 +: 32] | (hw_status[r*32 +: 32] & c_ro_mask[r*32 +: 32]);
      end
    end
  end

  always_comb begin
    rstate_d      = rstate_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        s_axi_arready = run_q;
        if (s_axi_arvalid && run_q) begin
          rdata_d  = rd_valid ? rd_word : 32'h0;
          rresp_d  = rd_valid ? c_resp_okay : c_resp_slverr;
          rstate_d = R_RDATA;
        end
      end
      R_RDATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign s_axi_bresp = bresp_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign reg_out     = store_q;
  assign reg_pulse   = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_regmap_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_regmap_responder
// Description : Self-checking bench: directed and random AXI4-Lite traffic against a register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_regmap_responder;

  localparam int AW = 6;
  localparam int NR = 8;
  localparam int NB = NR * 32;

  localparam logic [NB-1:0] P_RW  = {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF,
                                     32'hFFFF_FFFF, 32'h0000_FF00, 32'hFFFF_0000, 32'h0000_FFFF};
  localparam logic [NB-1:0] P_W1C = {32'h0, 32'h0, 32'h0, 32'h0,
                                     32'h0000_000F, 32'h0, 32'h0000_00FF, 32'h0};
  localparam logic [NB-1:0] P_W1S = {32'h0, 32'h0, 32'h0, 32'h0,
                                     32'h0000_00F0, 32'h0000_000F, 32'h0, 32'h0};
  localparam logic [NB-1:0] P_RST = {32'h0, 32'h0, 32'h0, 32'h0,
                                     32'hDEAD_BEEF, 32'h0000_5A00, 32'hABCD_0000, 32'h0000_1234};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic [NB-1:0] hw_status = '0, hw_set = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [NB-1:0] reg_out, reg_pulse;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]   m_store [NR];
  logic [NB-1:0] m_pulse;

  always #5 clk = ~clk;

  axi_regmap_responder #(
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NR),
    .RW_MASK    (P_RW),
    .W1C_MASK   (P_W1C),
    .W1S_MASK   (P_W1S),
    .RESET_VALUE(P_RST)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_awaddr (awaddr),
    .s_axi_awprot (3'b000),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_bresp  (bresp),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_araddr (araddr),
    .s_axi_arprot (3'b000),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .hw_status    (hw_status),
    .hw_set       (hw_set),
    .reg_out      (reg_out),
    .reg_pulse    (reg_pulse)
  );

  task automatic check_eq(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] byte_en(input logic [3:0] s);
    logic [31:0] be;
`ifdef AXI_REGMAP_WSTRB_EN
    for (int b = 0; b < 4; b++) be[b*8 +: 8] = {8{s[b]}};
`else
    be = 32'hFFFF_FFFF;
    if (s == 4'hF) be = 32'hFFFF_FFFF;
`endif
    return be;
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < NR; r++)
      m_store[r] = P_RST[r*32 +: 32] & P_RW[r*32 +: 32] & ~P_W1C[r*32 +: 32] & ~P_W1S[r*32 +: 32];
    m_pulse = '0;
  endfunction

  function automatic logic [NB-1:0] m_vec();
    logic [NB-1:0] v;
    for (int r = 0; r < NR; r++) v[r*32 +: 32] = m_store[r];
    return v;
  endfunction

  function automatic logic [33:0] model_read(input logic [AW-1:0] a);
    int r = int'(a[AW-1:2]);
    logic [31:0] ro;
    if (r >= NR) return {2'b10, 32'h0};
    ro = ~(P_RW[r*32 +: 32] | P_W1C[r*32 +: 32] | P_W1S[r*32 +: 32]);
    return {2'b00, m_store[r] | (hw_status[r*32 +: 32] & ro)};
  endfunction

  function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    int r = int'(a[AW-1:2]);
    logic [31:0] be = byte_en(s);
    logic [31:0] c, p, rw;
    m_pulse = '0;
    if (r >= NR) return 2'b10;
    c  = P_W1C[r*32 +: 32];
    p  = P_W1S[r*32 +: 32] & ~c;
    rw = P_RW[r*32 +: 32] & ~c & ~p;
    m_store[r] = (m_store[r] & ~(rw & be)) | (d & rw & be);
    m_store[r] = m_store[r] & ~(c & d & be);
    m_pulse[r*32 +: 32] = p & d & be;
    return 2'b00;
  endfunction

  function automatic void model_hw_set(input logic [NB-1:0] v);
    for (int r = 0; r < NR; r++) m_store[r] = m_store[r] | (v[r*32 +: 32] & P_W1C[r*32 +: 32]);
  endfunction

  function automatic logic [NB-1:0] rand_vec();
    logic [NB-1:0] v;
    for (int r = 0; r < NR; r++) v[r*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- bus tasks ----------------
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int hold,
                          input logic [NB-1:0] hs_vec, input bit rd_same);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0, lat = 1;
    logic [33:0] rexp = '0;
    logic [1:0]  bexp;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_hs   = awvalid && awready;
      w_hs    = wvalid && wready;
      step();
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("wr_handshake", NB'(aw_done && w_done), NB'(1));
    check_eq("bvalid_in_commit", NB'(bvalid), NB'(0));
    hw_set = hs_vec;
    if (rd_same) begin
      araddr = a; arvalid = 1'b1;
      rexp = model_read(a);
    end
    step();
    hw_set = '0; arvalid = 1'b0;
    bexp = model_write(a, d, s);
    model_hw_set(hs_vec);
    while (!bvalid && lat < 10) begin
      step();
      lat++;
    end
    check_eq("bvalid_latency", NB'(lat), NB'(1));
    check_eq("bresp", NB'(bresp), NB'(bexp));
    check_eq("reg_out_after_wr", reg_out, m_vec());
    check_eq("reg_pulse", reg_pulse, m_pulse);
    if (rd_same) begin
      check_eq("rd_same_cycle", NB'({rvalid, rresp, rdata}), NB'({1'b1, rexp}));
      rready = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      step();
      rready = 1'b0;
      if (i == 0) check_eq("reg_pulse_end", reg_pulse, '0);
      check_eq("b_hold", NB'({bvalid, bresp}), NB'({1'b1, bexp}));
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    check_eq("bvalid_drop", NB'(bvalid), NB'(0));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold);
    bit hs = 0;
    int cyc = 0;
    logic [33:0] rexp = '0;
    araddr = a; arvalid = 1'b1;
    while (!hs && cyc < 20) begin
      hs = arready;
      if (hs) rexp = model_read(a);
      step();
      cyc++;
    end
    arvalid = 1'b0;
    check_eq("rd_handshake", NB'(hs), NB'(1));
    check_eq("rd_data", NB'({rvalid, rresp, rdata}), NB'({1'b1, rexp}));
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq("rd_hold", NB'({rvalid, rresp, rdata}), NB'({1'b1, rexp}));
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    check_eq("rvalid_drop", NB'(rvalid), NB'(0));
  endtask

  task automatic pulse_hw(input logic [NB-1:0] v);
    hw_set = v;
    step();
    hw_set = '0;
    model_hw_set(v);
    check_eq("reg_out_hw_set", reg_out, m_vec());
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, NB'({awready, wready, arready, bvalid, rvalid}), NB'(0));
    check_eq({tag, "_data"}, NB'({bresp, rresp, rdata}), NB'(0));
    check_eq({tag, "_reg_out"}, reg_out, m_vec());
    check_eq({tag, "_reg_pulse"}, reg_pulse, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] bit35;
    model_reset();
    hw_status = rand_vec();
    repeat (3) step();
    check_reset_outputs("por");
    rst_n = 1'b1;
    step();

    do_read(6'h00, 1);
    do_write(6'h00, 32'hA5A5_A5A5, 4'hF, 2, 0, 3, '0, 1'b0);
    do_read(6'h00, 0);

    bit35 = '0;
    bit35[35] = 1'b1;
    pulse_hw(bit35);
    do_read(6'h04, 0);
    do_write(6'h04, 32'h0000_0008, 4'hF, 0, 0, 1, bit35, 1'b0);
    do_read(6'h04, 0);
    do_write(6'h04, 32'h0000_0008, 4'hF, 1, 0, 1, '0, 1'b0);
    do_read(6'h04, 0);

    do_write(6'h08, 32'h0000_0001, 4'hF, 0, 0, 2, '0, 1'b0);
    do_read(6'h08, 0);

    do_write(6'h3C, 32'hFFFF_FFFF, 4'hF, 0, 1, 1, '0, 1'b0);
    do_read(6'h3C, 1);

    do_write(6'h00, 32'hFFFF_FFFF, 4'h1, 0, 0, 1, '0, 1'b0);
    do_read(6'h00, 0);

    do_write(6'h10, 32'h1357_9BDF, 4'hF, 0, 0, 1, '0, 1'b1);
    do_write(6'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, 1, '0, 1'b1);
    do_read(6'h0C, 0);

    // abandon a write between its AW and W beats
    awaddr = 6'h10; awvalid = 1'b1;
    check_eq("aw_ready_pre_reset", NB'(awready), NB'(1));
    step();
    awvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async_rst");
    step();
    step();
    rst_n = 1'b1;
    #1;
    check_eq("ready_after_release", NB'({awready, wready, arready}), NB'(0));
    step();
    check_eq("ready_first_edge", NB'({awready, wready, arready}), NB'(3'b111));
    check_eq("reg_out_post_reset", reg_out, m_vec());
    do_write(6'h10, 32'h0BAD_F00D, 4'hF, 0, 1, 1, '0, 1'b0);
    do_read(6'h10, 0);

    for (int i = 0; i < 80; i++) begin
      int op = $urandom_range(0, 2);
      logic [AW-1:0] a = AW'($urandom_range(0, 63));
      hw_status = rand_vec();
      if (op == 0) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(1, 3), ($urandom_range(0, 1) == 1) ? rand_vec() : '0,
                 $urandom_range(0, 3) == 0);
      end else if (op == 1) begin
        do_read(a, $urandom_range(0, 2));
      end else begin
        pulse_hw(rand_vec());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
